deskew_frame_parser: RTL and testbench

//  Downstream of the two-lane deskew stage. Consumes the aligned 8-bit byte stream and its alignment flag.

---
 rtl/deskew_frame_parser.sv | 123 ++++++++++++
 tb/tb_deskew_frame_parser.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/deskew_frame_parser.sv
// deskew_frame_parser: finds MARKER/LEN/payload/CHK frames in the aligned byte stream,
// stages payload speculatively in a FIFO and exposes only checksum-verified frames.
module deskew_frame_parser #(
    parameter int         MAX_LEN    = 16,
    parameter int         FIFO_DEPTH = 32,
    parameter logic [7:0] MARKER     = 8'hAA
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_stream,
    input  logic                          i_aligned,
    output logic [7:0]                    o_data,
    output logic                          o_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_frame_ok,
    output logic                          o_chk_err,
    output logic                          o_len_err,
    output logic                          o_drop,
    output logic                          o_abort,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);
    localparam int         AW    = $clog2(FIFO_DEPTH);
    localparam int         CW    = (AW + 2 > 9) ? AW + 2 : 9;
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_SYNC, S_LEN, S_PAY, S_CHK, S_DROP} state_t;

    state_t      r_state;
    logic [8:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_spec_wptr;
    logic [AW:0] r_cmt_wptr;
    logic [AW:0] r_rptr;
    logic [8:0]  r_cnt;
    logic [7:0]  r_acc;
    logic        w_pop;
    logic        w_wr;
    logic [AW:0] w_used;
    logic [CW-1:0] w_free;

    assign o_valid = r_cmt_wptr != r_rptr;
    assign w_pop   = o_valid && i_ready;
    assign w_wr    = r_state == S_PAY && i_aligned;
    assign w_used  = r_spec_wptr - r_rptr;
    assign w_free  = CW'(FIFO_DEPTH) - CW'(w_used);
    assign o_level = r_cmt_wptr - r_rptr;
    // Head is gated so a freshly reset FIFO shows all-zero outputs.
    assign {o_last, o_data} = o_valid ? r_mem[r_rptr[AW-1:0]] : 9'd0;

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_spec_wptr[AW-1:0]] <= {r_cnt == 9'd1, i_stream};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_SYNC;
            r_spec_wptr <= '0;
            r_cmt_wptr  <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            o_frame_ok  <= 1'b0;
            o_chk_err   <= 1'b0;
            o_len_err   <= 1'b0;
            o_drop      <= 1'b0;
            o_abort     <= 1'b0;
        end else begin
            o_frame_ok <= 1'b0;
            o_chk_err  <= 1'b0;
            o_len_err  <= 1'b0;
            o_drop     <= 1'b0;
            o_abort    <= 1'b0;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            // Losing alignment mid-frame discards any speculative payload.
            if (r_state != S_SYNC && !i_aligned) begin
                r_spec_wptr <= r_cmt_wptr;
                o_abort     <= 1'b1;
                r_state     <= S_SYNC;
            end else begin
                case (r_state)
                    S_SYNC: if (i_aligned && i_stream == MARKER) r_state <= S_LEN;
                    S_LEN: begin
                        if (i_stream == 8'd0 || i_stream > MAX_B) begin
                            o_len_err <= 1'b1;
                            r_state   <= S_SYNC;
                        end else if (w_free < CW'(i_stream)) begin
                            r_cnt   <= {1'b0, i_stream} + 9'd1;
                            r_state <= S_DROP;
                        end else begin
                            r_cnt   <= {1'b0, i_stream};
                            r_acc   <= 8'd0;
                            r_state <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        r_spec_wptr <= r_spec_wptr + 1'b1;
                        r_acc       <= r_acc ^ i_stream;
                        r_cnt       <= r_cnt - 9'd1;
                        if (r_cnt == 9'd1) r_state <= S_CHK;
                    end
                    S_CHK: begin
                        if (i_stream == r_acc) begin
                            r_cmt_wptr <= r_spec_wptr;
                            o_frame_ok <= 1'b1;
                        end else begin
                            r_spec_wptr <= r_cmt_wptr;
                            o_chk_err   <= 1'b1;
                        end
                        r_state <= S_SYNC;
                    end
                    S_DROP: begin
                        r_cnt <= r_cnt - 9'd1;
                        if (r_cnt == 9'd1) begin
                            o_drop  <= 1'b1;
                            r_state <= S_SYNC;
                        end
                    end
                    default: r_state <= S_SYNC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_deskew_frame_parser.sv
// tb_deskew_frame_parser: directed frame sequences with hand-computed expectations
// plus a byte scoreboard for back-to-back frames under random backpressure.
module tb_deskew_frame_parser;
    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_stream;
    logic       i_aligned;
    logic [7:0] o_data;
    logic       o_last;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_ok;
    logic       o_chk_err;
    logic       o_len_err;
    logic       o_drop;
    logic       o_abort;
    logic [5:0] o_level;

    int         n_vec = 0;
    int         n_err = 0;
    logic       sb_on = 1'b0;
    logic       rand_rdy = 1'b0;
    logic [8:0] sb_q[$];

    deskew_frame_parser dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stream(i_stream), .i_aligned(i_aligned),
        .o_data(o_data), .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready),
        .o_frame_ok(o_frame_ok), .o_chk_err(o_chk_err), .o_len_err(o_len_err),
        .o_drop(o_drop), .o_abort(o_abort), .o_level(o_level)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] st();
        return {o_frame_ok, o_chk_err, o_len_err, o_drop, o_abort};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] b, input logic al);
        logic [9:0] exp;
        i_stream  = b;
        i_aligned = al;
        if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
        if (sb_on && o_valid && i_ready) begin
            exp = (sb_q.size() > 0) ? {1'b1, sb_q.pop_front()} : 10'h0;
            chk("sb_byte", {22'd0, 1'b1, o_last, o_data}, {22'd0, exp});
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] base, input logic [7:0] len, input logic push);
        logic [7:0] acc;
        logic [7:0] b;
        acc = 8'd0;
        step(8'hAA, 1'b1);
        step(len, 1'b1);
        for (int i = 0; i < int'(len); i++) begin
            b   = 8'(base + 8'(i));
            acc = acc ^ b;
            if (push) sb_q.push_back({i == int'(len) - 1, b});
            step(b, 1'b1);
        end
        step(acc, 1'b1);
    endtask

    initial begin
        i_rst = 1'b1; i_stream = 8'd0; i_aligned = 1'b0; i_ready = 1'b0;
        @(posedge i_clk); @(posedge i_clk); #1;
        chk("rst_out", {21'd0, st(), o_valid, o_last, o_data}, 32'd0);
        chk("rst_level", {26'd0, o_level}, 32'd0);
        i_rst = 1'b0;
        step(8'h00, 1'b0);

        // 1: good 3-byte frame, then drain
        step(8'hAA, 1'b1); step(8'h03, 1'b1);
        step(8'h11, 1'b1); step(8'h22, 1'b1); step(8'h33, 1'b1); step(8'h00, 1'b1);
        chk("t1_status", {27'd0, st()}, 32'b10000);
        chk("t1_level3", {26'd0, o_level}, 32'd3);
        chk("t1_head", {23'd0, o_valid, o_last, o_data}, {23'd0, 1'b1, 1'b0, 8'h11});
        i_ready = 1'b1;
        step(8'h00, 1'b0);
        chk("t1_pulse_gone", {27'd0, st()}, 32'd0);
        chk("t1_b2", {20'd0, o_level, o_valid, o_last, o_data}, {20'd0, 6'd2, 1'b1, 1'b0, 8'h22});
        step(8'h00, 1'b0);
        chk("t1_b3", {20'd0, o_level, o_valid, o_last, o_data}, {20'd0, 6'd1, 1'b1, 1'b1, 8'h33});
        step(8'h00, 1'b0);
        chk("t1_empty", {25'd0, o_level, o_valid}, 32'd0);

        // 2: checksum mismatch
        i_ready = 1'b0;
        step(8'hAA, 1'b1); step(8'h02, 1'b1); step(8'h05, 1'b1); step(8'h06, 1'b1); step(8'h07, 1'b1);
        chk("t2_status", {27'd0, st()}, 32'b01000);
        chk("t2_empty", {25'd0, o_level, o_valid}, 32'd0);

        // 3: zero length, over-length, then 1-byte frame left unread
        step(8'hAA, 1'b1); step(8'h00, 1'b1);
        chk("t3_len0", {27'd0, st()}, 32'b00100);
        step(8'hAA, 1'b1); step(8'h11, 1'b1);
        chk("t3_len17", {27'd0, st()}, 32'b00100);
        step(8'hAA, 1'b1); step(8'h10, 1'b0);
        chk("t3_abort_in_len", {27'd0, st()}, 32'b00001);
        step(8'hAA, 1'b1); step(8'h01, 1'b1); step(8'h5A, 1'b1); step(8'h5A, 1'b1);
        chk("t3_status", {27'd0, st()}, 32'b10000);
        chk("t3_head", {20'd0, o_level, o_valid, o_last, o_data}, {20'd0, 6'd1, 1'b1, 1'b1, 8'h5A});

        // 4: alignment loss mid-payload, then a frame commits after the held byte
        step(8'hAA, 1'b1); step(8'h04, 1'b1); step(8'h01, 1'b1); step(8'h02, 1'b1);
        step(8'h03, 1'b0);
        chk("t4_abort", {27'd0, st()}, 32'b00001);
        chk("t4_held", {20'd0, o_level, o_valid, o_last, o_data}, {20'd0, 6'd1, 1'b1, 1'b1, 8'h5A});
        step(8'hAA, 1'b1); step(8'h01, 1'b1); step(8'h77, 1'b1); step(8'h77, 1'b1);
        chk("t4_status", {27'd0, st()}, 32'b10000);
        chk("t4_level2", {26'd0, o_level}, 32'd2);
        i_ready = 1'b1;
        step(8'h00, 1'b0);
        chk("t4_b2", {20'd0, o_level, o_valid, o_last, o_data}, {20'd0, 6'd1, 1'b1, 1'b1, 8'h77});
        step(8'h00, 1'b0);
        chk("t4_empty", {25'd0, o_level, o_valid}, 32'd0);

        // 5: fill exactly to 32, third frame dropped, then drain across the wrap
        i_ready = 1'b0;
        send_frame(8'h10, 8'd16, 1'b0);
        chk("t5_level16", {21'd0, st(), o_level}, {21'd0, 5'b10000, 6'd16});
        send_frame(8'h40, 8'd16, 1'b0);
        chk("t5_level32", {21'd0, st(), o_level}, {21'd0, 5'b10000, 6'd32});
        send_frame(8'h80, 8'd16, 1'b0);
        chk("t5_drop", {21'd0, st(), o_level}, {21'd0, 5'b00010, 6'd32});
        i_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("t5_pop", {22'd0, o_valid, o_last, o_data},
                {22'd0, 1'b1, i == 15 || i == 31, (i < 16) ? 8'(8'h10 + 8'(i)) : 8'(8'h30 + 8'(i))});
            step(8'h00, 1'b0);
        end
        chk("t5_empty", {25'd0, o_level, o_valid}, 32'd0);

        // 6: back-to-back frames under random backpressure
        sb_on = 1'b1; rand_rdy = 1'b1;
        send_frame(8'hA1, 8'd3, 1'b1);
        send_frame(8'h07, 8'd5, 1'b1);
        send_frame(8'hE3, 8'd4, 1'b1);
        rand_rdy = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 40 && sb_q.size() > 0; k++) step(8'h00, 1'b0);
        chk("t6_drained", sb_q.size(), 32'd0);
        chk("t6_empty", {25'd0, o_level, o_valid}, 32'd0);
        sb_on = 1'b0;

        // reset mid-PAY with committed data present
        i_ready = 1'b0;
        step(8'hAA, 1'b1); step(8'h01, 1'b1); step(8'h21, 1'b1); step(8'h21, 1'b1);
        chk("t6_pre_rst", {26'd0, o_level}, 32'd1);
        step(8'hAA, 1'b1); step(8'h08, 1'b1); step(8'h01, 1'b1); step(8'h02, 1'b1);
        i_rst = 1'b1;
        #1;
        chk("t6_rst_out", {21'd0, st(), o_valid, o_last, o_data}, 32'd0);
        chk("t6_rst_level", {26'd0, o_level}, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        step(8'h03, 1'b1); step(8'h04, 1'b1);
        step(8'hAA, 1'b1); step(8'h01, 1'b1); step(8'h33, 1'b1); step(8'h33, 1'b1);
        chk("t6_after_rst", {14'd0, st(), o_level, o_valid, o_last, o_data},
            {14'd0, 5'b10000, 6'd1, 1'b1, 1'b1, 8'h33});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
